// File: rtl/mult_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier evaluation blocks.
package mult_eval_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sweep_state_t;

   // Wide enough for the signed difference of two 2*WIDTH+1 operands up to WIDTH=32.
   localparam int unsigned ED_MAX_W = 65;

   function automatic logic [ED_MAX_W-1:0] abs_diff(
      input logic signed [ED_MAX_W-1:0] x,
      input logic signed [ED_MAX_W-1:0] y
   );
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/mult_err_pipe.sv
// LAT-deep delay line carrying {valid, a, b, exact} alongside the multiplier under test.
module mult_err_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [2*WIDTH-1:0] in_exact,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic [2*WIDTH-1:0] out_exact
);

   localparam int unsigned EN = 1 + 4*WIDTH;

   logic [EN-1:0]     entry_in;
   logic [LAT*EN-1:0] chain_q;
   logic [LAT*EN-1:0] chain_d;

   assign entry_in = {in_valid, in_a, in_b, in_exact};

   // Stage 0 sits in the low slice; the oldest entry is the top slice.
   if (LAT == 1) begin : g_one
      always_comb begin
         chain_d = entry_in;
      end
   end else begin : g_many
      always_comb begin
         chain_d = {chain_q[(LAT-1)*EN-1:0], entry_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain_q <= '0;
      else     chain_q <= chain_d;
   end

   assign {out_valid, out_a, out_b, out_exact} = chain_q[LAT*EN-1 -: EN];

endmodule

// File: rtl/mult_err_sweep.sv
// Exhaustive operand sweep of an external multiplier, accumulating error-distance
// statistics (sum, max with operands, mismatch count) against the exact product.
module mult_err_sweep
   import mult_eval_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LAT    = 2,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned SUM_W  = 4*WIDTH+1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dut_a,
   output logic [WIDTH-1:0]   dut_b,
   input  logic [2*WIDTH-1:0] dut_y,
   output logic [SUM_W-1:0]   err_sum,
   output logic [2*WIDTH:0]   err_max,
   output logic [WIDTH-1:0]   worst_a,
   output logic [WIDTH-1:0]   worst_b,
   output logic [2*WIDTH:0]   mismatch_cnt
);

   localparam int unsigned PW = 2*WIDTH;
   localparam int unsigned EW = PW + 1;
   localparam int unsigned DW = $clog2(LAT + 1);
   localparam logic [EW-1:0] LAST_PAIR = {1'b0, {PW{1'b1}}};

   sweep_state_t state_q, state_d;
   logic [EW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [EW-1:0]    max_q, max_d;
   logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
   logic [EW-1:0]    mm_q, mm_d;

   logic signed [PW-1:0] sa, sb;
   logic [PW-1:0]        ua, ub, exact_in;
   logic                 chk_valid;
   logic [WIDTH-1:0]     chk_a, chk_b;
   logic [PW-1:0]        chk_exact;
   logic signed [EW-1:0] y_s, x_s;
   logic [ED_MAX_W-1:0]  ed_wide;
   logic [EW-1:0]        ed;

   always_comb begin
      sa = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      sb = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      ua = {{WIDTH{1'b0}}, a_q};
      ub = {{WIDTH{1'b0}}, b_q};
      exact_in = (SIGNED != 0) ? sa * sb : ua * ub;
   end

   mult_err_pipe #(
      .WIDTH (WIDTH),
      .LAT   (LAT)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (state_q == RUN),
      .in_a      (a_q),
      .in_b      (b_q),
      .in_exact  (exact_in),
      .out_valid (chk_valid),
      .out_a     (chk_a),
      .out_b     (chk_b),
      .out_exact (chk_exact)
   );

   always_comb begin
      y_s = (SIGNED != 0) ? {dut_y[PW-1], dut_y} : {1'b0, dut_y};
      x_s = (SIGNED != 0) ? {chk_exact[PW-1], chk_exact} : {1'b0, chk_exact};
      ed_wide = abs_diff(ED_MAX_W'(y_s), ED_MAX_W'(x_s));
      ed = ed_wide[EW-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      drain_d = drain_q;
      sum_d   = sum_q;
      max_d   = max_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      mm_d    = mm_q;

      if (chk_valid) begin
         sum_d = sum_q + SUM_W'(ed);
         if (ed_wide != '0) mm_d = mm_q + EW'(1);
         // Strict compare keeps the first pair on ties.
         if (ed > max_q) begin
            max_d = ed;
            wa_d  = chk_a;
            wb_d  = chk_b;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               a_d     = '0;
               b_d     = '0;
               sum_d   = '0;
               max_d   = '0;
               wa_d    = '0;
               wb_d    = '0;
               mm_d    = '0;
            end
         end
         RUN: begin
            if (cnt_q == LAST_PAIR) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               cnt_d      = cnt_q + EW'(1);
               {a_d, b_d} = {a_q, b_q} + PW'(1);
            end
         end
         DRAIN: begin
            if (drain_q == DW'(LAT)) state_d = DONE;
            else                     drain_d = drain_q + DW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         drain_q <= '0;
         sum_q   <= '0;
         max_q   <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
         mm_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         drain_q <= drain_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
         mm_q    <= mm_d;
      end
   end

   assign busy         = (state_q == RUN) || (state_q == DRAIN);
   assign done         = (state_q == DONE);
   assign dut_a        = a_q;
   assign dut_b        = b_q;
   assign err_sum      = sum_q;
   assign err_max      = max_q;
   assign worst_a      = wa_q;
   assign worst_b      = wb_q;
   assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_mult_err_sweep.sv
// Scoreboard bench for mult_err_sweep: four parameterisations driven by behavioural
// multiplier models; expected statistics are pushed at start and checked on done.
module tb_mult_err_sweep;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] start_v;
   int unsigned cyc = 0;
   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // d0: WIDTH=8 LAT=2 exact model
   logic        s0_busy, s0_done;
   logic [7:0]  s0_a, s0_b, s0_wa, s0_wb;
   logic [15:0] s0_y, y0_p1, y0_p2;
   logic [32:0] s0_sum;
   logic [16:0] s0_max, s0_mm;
   // d1: WIDTH=4 LAT=1 y=0
   logic        s1_busy, s1_done;
   logic [3:0]  s1_a, s1_b, s1_wa, s1_wb;
   logic [16:0] s1_sum;
   logic [8:0]  s1_max, s1_mm;
   // d2: WIDTH=4 LAT=3 exact with bit0 cleared
   logic        s2_busy, s2_done;
   logic [3:0]  s2_a, s2_b, s2_wa, s2_wb;
   logic [7:0]  s2_y, y2_p1, y2_p2, y2_p3;
   logic [16:0] s2_sum;
   logic [8:0]  s2_max, s2_mm;
   // d3: WIDTH=4 SIGNED LAT=1 y=0
   logic        s3_busy, s3_done;
   logic [3:0]  s3_a, s3_b, s3_wa, s3_wb;
   logic [16:0] s3_sum;
   logic [8:0]  s3_max, s3_mm;

   always @(posedge clk) begin
      y0_p1 <= 16'(s0_a) * 16'(s0_b);
      y0_p2 <= y0_p1;
      y2_p1 <= (8'(s2_a) * 8'(s2_b)) & 8'hFE;
      y2_p2 <= y2_p1;
      y2_p3 <= y2_p2;
   end
   assign s0_y = y0_p2;
   assign s2_y = y2_p3;

   mult_err_sweep #(.WIDTH(8), .LAT(2), .SIGNED(0), .SUM_W(33)) u_d0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(s0_busy), .done(s0_done),
      .dut_a(s0_a), .dut_b(s0_b), .dut_y(s0_y), .err_sum(s0_sum), .err_max(s0_max),
      .worst_a(s0_wa), .worst_b(s0_wb), .mismatch_cnt(s0_mm));
   mult_err_sweep #(.WIDTH(4), .LAT(1), .SIGNED(0), .SUM_W(17)) u_d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(s1_busy), .done(s1_done),
      .dut_a(s1_a), .dut_b(s1_b), .dut_y(8'h00), .err_sum(s1_sum), .err_max(s1_max),
      .worst_a(s1_wa), .worst_b(s1_wb), .mismatch_cnt(s1_mm));
   mult_err_sweep #(.WIDTH(4), .LAT(3), .SIGNED(0), .SUM_W(17)) u_d2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(s2_busy), .done(s2_done),
      .dut_a(s2_a), .dut_b(s2_b), .dut_y(s2_y), .err_sum(s2_sum), .err_max(s2_max),
      .worst_a(s2_wa), .worst_b(s2_wb), .mismatch_cnt(s2_mm));
   mult_err_sweep #(.WIDTH(4), .LAT(1), .SIGNED(1), .SUM_W(17)) u_d3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .busy(s3_busy), .done(s3_done),
      .dut_a(s3_a), .dut_b(s3_b), .dut_y(8'h00), .err_sum(s3_sum), .err_max(s3_max),
      .worst_a(s3_wa), .worst_b(s3_wb), .mismatch_cnt(s3_mm));

   typedef struct {
      int              id;
      longint unsigned k, lat, sum, mx, wa, wb, mm;
   } exp_t;
   exp_t sb_q[$];

   logic [3:0] done_v;
   logic [3:0] done_prev = '0;
   assign done_v = {s3_done, s2_done, s1_done, s0_done};

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic get_act(input int id, output longint unsigned busy, done, sum, mx, wa, wb, mm, oa, ob);
      case (id)
         0: begin busy = s0_busy; done = s0_done; sum = s0_sum; mx = s0_max; wa = s0_wa; wb = s0_wb; mm = s0_mm; oa = s0_a; ob = s0_b; end
         1: begin busy = s1_busy; done = s1_done; sum = s1_sum; mx = s1_max; wa = s1_wa; wb = s1_wb; mm = s1_mm; oa = s1_a; ob = s1_b; end
         2: begin busy = s2_busy; done = s2_done; sum = s2_sum; mx = s2_max; wa = s2_wa; wb = s2_wb; mm = s2_mm; oa = s2_a; ob = s2_b; end
         default: begin busy = s3_busy; done = s3_done; sum = s3_sum; mx = s3_max; wa = s3_wa; wb = s3_wb; mm = s3_mm; oa = s3_a; ob = s3_b; end
      endcase
   endtask

   // Monitor: every rising done pops one expectation and compares it.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (done_v[i] && !done_prev[i]) begin
            longint unsigned busy, dn, sum, mx, wa, wb, mm, oa, ob;
            exp_t e;
            get_act(i, busy, dn, sum, mx, wa, wb, mm, oa, ob);
            if (sb_q.size() == 0) begin
               chk($sformatf("d%0d_unexpected_done", i), 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("d%0d_id", i), longint'(i), longint'(e.id));
               chk($sformatf("d%0d_latency", i), longint'(cyc) - e.k, e.lat);
               chk($sformatf("d%0d_busy", i), busy, 0);
               chk($sformatf("d%0d_err_sum", i), sum, e.sum);
               chk($sformatf("d%0d_err_max", i), mx, e.mx);
               chk($sformatf("d%0d_worst_a", i), wa, e.wa);
               chk($sformatf("d%0d_worst_b", i), wb, e.wb);
               chk($sformatf("d%0d_mismatch", i), mm, e.mm);
            end
         end
      end
      done_prev = done_v;
   end

   task automatic push_and_start(input int id, input longint unsigned lat, sum, mx, wa, wb, mm);
      exp_t e;
      e.id = id; e.k = cyc + 1; e.lat = lat;
      e.sum = sum; e.mx = mx; e.wa = wa; e.wb = wb; e.mm = mm;
      sb_q.push_back(e);
      start_v[id] = 1'b1;
      @(negedge clk);
      start_v[id] = 1'b0;
   endtask

   task automatic wait_done(input int id, input int budget);
      int n = 0;
      while (!done_v[id] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done_v[id]) chk($sformatf("d%0d_done_timeout", id), 0, 1);
   endtask

   task automatic check_zero(input int id, input string tag);
      longint unsigned busy, dn, sum, mx, wa, wb, mm, oa, ob;
      get_act(id, busy, dn, sum, mx, wa, wb, mm, oa, ob);
      chk($sformatf("%s_d%0d_busy", tag, id), busy, 0);
      chk($sformatf("%s_d%0d_done", tag, id), dn, 0);
      chk($sformatf("%s_d%0d_sum", tag, id), sum, 0);
      chk($sformatf("%s_d%0d_max", tag, id), mx, 0);
      chk($sformatf("%s_d%0d_mm", tag, id), mm, 0);
      chk($sformatf("%s_d%0d_worst", tag, id), wa | wb, 0);
      chk($sformatf("%s_d%0d_ab", tag, id), oa | ob, 0);
   endtask

   initial begin
      rst = 1'b1;
      start_v = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) check_zero(i, "rst_init");
      rst = 1'b0;
      @(negedge clk);

      // Exact 8x8 multiplier: zero error, done N+LAT+1 edges after start.
      push_and_start(0, 65539, 0, 0, 0, 0, 0);
      wait_done(0, 70000);

      // Zero output: ED = a*b.
      push_and_start(1, 258, 14400, 225, 15, 15, 225);
      wait_done(1, 400);

      // bit0 dropped: error 1 for each odd*odd pair.
      push_and_start(2, 260, 64, 1, 1, 1, 64);
      wait_done(2, 400);

      // Signed zero output: max |a*b| at (-8,-8).
      push_and_start(3, 258, 4096, 64, 8, 8, 225);
      wait_done(3, 400);

      // Reset 100 cycles into a sweep aborts everything.
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (100) @(negedge clk);
      chk("pre_rst_busy", s1_busy, 1);
      rst = 1'b1;
      #1;
      check_zero(1, "rst_mid");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero(1, "rst_after");
      push_and_start(1, 258, 14400, 225, 15, 15, 225);
      wait_done(1, 400);

      // start in RUN is ignored: latency still counted from the first start.
      push_and_start(1, 258, 14400, 225, 15, 15, 225);
      repeat (50) @(negedge clk);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      wait_done(1, 400);
      repeat (5) @(negedge clk);
      chk("done_hold", s1_done, 1);
      chk("done_sum_stable", s1_sum, 14400);
      chk("done_mm_stable", s1_mm, 225);

      // start in DONE clears stats and reruns.
      push_and_start(1, 258, 14400, 225, 15, 15, 225);
      chk("restart_done_low", s1_done, 0);
      chk("restart_busy", s1_busy, 1);
      chk("restart_sum_clr", s1_sum, 0);
      chk("restart_max_clr", s1_max, 0);
      chk("restart_mm_clr", s1_mm, 0);
      wait_done(1, 400);

      repeat (3) @(negedge clk);
      chk("sb_leftover", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
